// File: rtl/mul_pkg.sv
// Shared constants and state encoding for the sequential shift-and-add multiplier.
package mul_pkg;

  localparam int WIDTH     = 16;
  localparam int LAST_ITER = WIDTH - 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mbledhesi16b.sv
// 16-bit ripple-carry adder with zero carry-in.
module mbledhesi16b (
  input  logic [15:0] A,
  input  logic [15:0] B,
  output logic [15:0] REZ,
  output logic        CarryOut
);

  logic [16:0] carry;

  assign carry[0] = 1'b0;

  for (genvar i = 0; i < 16; i++) begin : g_fa
    assign REZ[i]     = A[i] ^ B[i] ^ carry[i];
    assign carry[i+1] = (A[i] & B[i]) | (carry[i] & (A[i] ^ B[i]));
  end

  assign CarryOut = carry[16];

endmodule

// File: rtl/shumezuesi_seq16b.sv
// Multi-cycle unsigned 16x16 shift-and-add multiplier with Start/Busy/Done handshake.
// WIDTH is fixed at 16 because the adder instance is a fixed 16-bit ripple adder.
module shumezuesi_seq16b #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic                 Clock,
  input  logic                 Reset_n,
  input  logic                 Start,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 Busy,
  output logic                 Done,
  output logic [2*WIDTH-1:0]   Product,
  output logic                 Overflow
);

  import mul_pkg::*;

  state_t             state, state_next;
  logic [WIDTH-1:0]   m;
  logic [2*WIDTH-1:0] p;
  logic [2*WIDTH-1:0] p_next;
  logic [CNT_W-1:0]   count;
  logic [WIDTH-1:0]   s;
  logic               c;
  logic               last;

  mbledhesi16b u_add (
    .A        (p[2*WIDTH-1:WIDTH]),
    .B        (m),
    .REZ      (s),
    .CarryOut (c)
  );

  // The adder carry lands in P[31] after the shift, so no product bit is lost.
  assign p_next = p[0] ? {c, s, p[WIDTH-1:1]}
                       : {1'b0, p[2*WIDTH-1:WIDTH], p[WIDTH-1:1]};
  assign last   = (count == CNT_W'(LAST_ITER));

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: if (Start) state_next = ST_RUN;
      ST_RUN:  if (last)  state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    Busy = (state == ST_RUN);
    Done = (state == ST_DONE);
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      m        <= '0;
      p        <= '0;
      count    <= '0;
      Product  <= '0;
      Overflow <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (Start) begin
            m     <= A;
            p     <= {{WIDTH{1'b0}}, B};
            count <= '0;
          end
        end
        ST_RUN: begin
          p     <= p_next;
          count <= count + CNT_W'(1);
          if (last) begin
            Product  <= p_next;
            Overflow <= |p_next[2*WIDTH-1:WIDTH];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/shumezuesi_seq16b.md
Name: shumezuesi_seq16b

Overview:
Multi-cycle unsigned 16x16 shift-and-add multiplier for the CPU's MUL instruction. Each iteration it drives the 16-bit ripple adder with the partial product's upper half and the multiplicand. It then consumes the adder's sum and carry-out.
The result is a 32-bit product with Start/Busy/Done handshake to the control unit.

Parameters:
WIDTH, 16, operand width; only 16 is supported because the adder instance is fixed at 16 bits.
CNT_W, 5, iteration-counter width; must hold 0..WIDTH.

Ports:
Clock  input  1  single system clock, rising-edge.
Reset_n  input  1  asynchronous, active-low reset.
Start  input  1  request; sampled only in IDLE.
A  input  16  multiplicand; captured on accepted Start.
B  input  16  multiplier; captured on accepted Start.
Busy  output  1  high while in RUN.
Done  output  1  one-cycle pulse when Product is updated.
Product  output  32  unsigned A*B; held until the next Done.
Overflow  output  1  Product[31:16] != 0; registered with Product.

Behaviour:
- Reset (async, Reset_n=0):
  - state=IDLE; Busy=0, Done=0, Product=0, Overflow=0.
  - Internal M, P and count are cleared.
  - Reset asserted mid-RUN aborts the operation; no Done is produced.
- States and transitions:
  - IDLE: on a rising edge with Start=1, load M<=A, P<={16'h0000,B}, count<=0, and go to RUN. Start=0 stays in IDLE.
  - RUN: one iteration per edge.
    - The adder computes {c,s}=P[31:16]+M with carry-in 0.
    - If P[0]=1: P<={c,s,P[15:1]}.
    - Else: P<={1'b0,P[31:16],P[15:1]}.
    - count<=count+1.
    - On the edge where count==15 (16th iteration), also load Product<=next P and Overflow<=(next P[31:16]!=0), then go to DONE.
  - DONE: Done=1 for exactly this one cycle, then unconditionally go to IDLE on the next edge.
- Handshake:
  - Busy=1 exactly in RUN.
  - Start in RUN or DONE is ignored; it is not queued.
  - Start is accepted again in the IDLE cycle following DONE.
- Latency:
  - Start sampled at edge k.
  - Iterations occur at edges k+1..k+16.
  - Done is high in the cycle after edge k+16.
  - Back-to-back minimum issue interval is 18 cycles.
- Width rules:
  - All arithmetic is unsigned modulo 2^16 per adder pass.
  - The carry-out becomes P[31] after the shift, so no product bits are lost; the maximum is 0xFFFE0001.
- Operand stability: A and B may change freely after the accepting edge.
- Product/Overflow change only on the DONE-entry edge or on reset.
- Zero operands still take the full 16 iterations; there is no early termination.

Decomposition:
- Shared package mul_pkg holds:
  - state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
  - the WIDTH constant;
  - LAST_ITER=WIDTH-1.
- One sub-module instance: the team's existing 16-bit ripple adder mbledhesi16b (port order A, B, REZ, CarryOut). Its carry-out is used as an output net driving c.
- All other logic (FSM, counter, P/M registers) is flat in this module.

Test Plan:
- Reset, then A=3, B=5, Start for one cycle. Required: Busy=1 for 16 cycles; Done pulses once at k+17; Product=32'h0000000F; Overflow=0.
- A=16'hFFFF, B=16'hFFFF. Required: Product=32'hFFFE0001, Overflow=1; checks carry propagation into P[31].
- A=16'h1234, B=0, then A=0, B=16'hABCD. Required: both give Product=0, Overflow=0, Done still at k+17.
- Start with A=7, B=9; reapply Start with A=2, B=2 at k+5 and during DONE. Required: both ignored; Product=63; exactly one Done.
- Start with A=100, B=200; pull Reset_n low at k+8 asynchronously (mid-cycle). Required: Busy, Done, Product and Overflow go to 0 immediately; no Done after release; a new Start gives a correct result.
- 200 random A/B pairs issued back-to-back at the 18-cycle interval. Required: Product==A*B on every Done; Product stable between Dones.
